// File: rtl/watch_fnd_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// watch_fnd_ctrl_pkg
// Shared constants and types for the watch 4-digit FND display controller.
//   SEG_0..SEG_9 : active-low {dp,g,f,e,d,c,b,a} patterns, dp off
//   SEG_BLANK    : all segments dark
//   NUM_DIGITS   : number of multiplexed digits
//   DP_BLINK_THRESH : msec value below which the centre dot is lit
// ---------------------------------------------------------------------------
package watch_fnd_ctrl_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam int         NUM_DIGITS      = 4;
  localparam logic [6:0] DP_BLINK_THRESH = 7'd50;

  // Scan position; DIG_0 is the rightmost digit.
  typedef enum logic [1:0] {
    DIG_0 = 2'd0,
    DIG_1 = 2'd1,
    DIG_2 = 2'd2,
    DIG_3 = 2'd3
  } digit_idx_t;

  // Frame snapshot: low pair, high pair and the msec value driving the dot.
  typedef struct packed {
    logic [6:0] low;
    logic [5:0] high;
    logic [6:0] dot;
  } snapshot_t;

  // Active-low one-hot digit enable for a scan position.
  function automatic logic [3:0] com_for(digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/watch_fnd_ctrl_if.sv
// ---------------------------------------------------------------------------
// watch_fnd_ctrl_if
// Time fields in, display drive out.
//   master : time source / display consumer (drives msec..sel_mode)
//   slave  : display controller (drives fnd_com, fnd_data)
// ---------------------------------------------------------------------------
interface watch_fnd_ctrl_if;
  logic [6:0] msec;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic       sel_mode;
  logic [3:0] fnd_com;
  logic [7:0] fnd_data;

  modport master (
    output msec, sec, min, hour, sel_mode,
    input  fnd_com, fnd_data
  );

  modport slave (
    input  msec, sec, min, hour, sel_mode,
    output fnd_com, fnd_data
  );
endinterface

// File: rtl/watch_fnd_ctrl_fnd_seg_decoder.sv
// ---------------------------------------------------------------------------
// fnd_seg_decoder
// Combinational digit to 7-segment conversion, active-low {g,f,e,d,c,b,a}.
//   i_digit : 4-bit digit value; 10..15 produce all segments dark
//   o_seg   : 7-bit segment pattern
// ---------------------------------------------------------------------------
module fnd_seg_decoder
  import watch_fnd_ctrl_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  // Digit lookup; anything outside 0..9 is blanked.
  always_comb begin
    o_seg = SEG_BLANK[6:0];
    case (i_digit)
      4'd0:    o_seg = SEG_0[6:0];
      4'd1:    o_seg = SEG_1[6:0];
      4'd2:    o_seg = SEG_2[6:0];
      4'd3:    o_seg = SEG_3[6:0];
      4'd4:    o_seg = SEG_4[6:0];
      4'd5:    o_seg = SEG_5[6:0];
      4'd6:    o_seg = SEG_6[6:0];
      4'd7:    o_seg = SEG_7[6:0];
      4'd8:    o_seg = SEG_8[6:0];
      4'd9:    o_seg = SEG_9[6:0];
      default: o_seg = SEG_BLANK[6:0];
    endcase
  end

endmodule

// File: rtl/watch_fnd_ctrl.sv
// ---------------------------------------------------------------------------
// watch_fnd_ctrl
// Multiplexed 4-digit FND driver showing SS.CC (sel_mode=0) or HH.MM
// (sel_mode=1). A frame snapshot is taken at each index-0 wrap so a frame
// never mixes old and new time values.
//   clk   : clock, rising edge active
//   reset : asynchronous, active-high
//   bus   : watch_fnd_ctrl_if.slave (time fields in, fnd_com/fnd_data out)
// ---------------------------------------------------------------------------
module watch_fnd_ctrl
  import watch_fnd_ctrl_pkg::*;
#(
  parameter int SCAN_COUNT = 100_000
) (
  input logic              clk,
  input logic              reset,
  watch_fnd_ctrl_if.slave  bus
);

  localparam int CNT_W = (SCAN_COUNT > 1) ? $clog2(SCAN_COUNT) : 1;

  logic [CNT_W-1:0] r_cnt;
  digit_idx_t       r_idx;
  snapshot_t        r_snap;
  logic [3:0]       r_com;
  logic [7:0]       r_data;

  logic             w_tick;
  digit_idx_t       w_idx_nxt;
  snapshot_t        w_snap_nxt;
  snapshot_t        w_src;
  logic [3:0]       w_digit;
  logic [6:0]       w_seg;
  logic             w_dp_n;
  logic [7:0]       w_data_nxt;

  // Scan tick and next scan position.
  always_comb begin
    w_tick    = (r_cnt == CNT_W'(SCAN_COUNT - 1));
    w_idx_nxt = digit_idx_t'(r_idx + 2'd1);
  end

  // Candidate snapshot built from the live inputs under the current sel_mode.
  always_comb begin
    w_snap_nxt.dot = bus.msec;
    if (bus.sel_mode) begin
      w_snap_nxt.low  = {1'b0, bus.min};
      w_snap_nxt.high = {1'b0, bus.hour};
    end else begin
      w_snap_nxt.low  = bus.msec;
      w_snap_nxt.high = bus.sec;
    end
  end

  // Digit for the next position: index 0 uses the snapshot being latched on
  // this edge, the others use the stored frame snapshot.
  always_comb begin
    if (w_idx_nxt == DIG_0) begin
      w_src = w_snap_nxt;
    end else begin
      w_src = r_snap;
    end
    case (w_idx_nxt)
      DIG_0:   w_digit = 4'(w_src.low  % 7'd10);
      DIG_1:   w_digit = 4'(w_src.low  / 7'd10);
      DIG_2:   w_digit = 4'(w_src.high % 6'd10);
      DIG_3:   w_digit = 4'(w_src.high / 6'd10);
      default: w_digit = 4'd15;
    endcase
  end

  fnd_seg_decoder u_seg_dec (
    .i_digit (w_digit),
    .o_seg   (w_seg)
  );

  // Dot blinks on the middle digit during the first half of each second.
  always_comb begin
    w_dp_n = ~((w_idx_nxt == DIG_2) && (w_src.dot < DP_BLINK_THRESH));
    if (w_digit >= 4'd10) begin
      w_data_nxt = SEG_BLANK;
    end else begin
      w_data_nxt = {w_dp_n, w_seg};
    end
  end

  // Scan-rate counter and digit index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= DIG_0;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_idx <= w_idx_nxt;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Frame snapshot, refreshed only when the scan wraps back to index 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_snap <= '0;
    end else if (w_tick && (w_idx_nxt == DIG_0)) begin
      r_snap <= w_snap_nxt;
    end
  end

  // Registered display drive, loaded once per scan step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_com  <= 4'b1111;
      r_data <= SEG_BLANK;
    end else if (w_tick) begin
      r_com  <= com_for(w_idx_nxt);
      r_data <= w_data_nxt;
    end
  end

  assign bus.fnd_com  = r_com;
  assign bus.fnd_data = r_data;

endmodule
